// File: rtl/rotor_pkg.sv
// Shared types and helpers for the rotor step/direction driver.
// Wrap-around positioning is selected with the ROTOR_WRAP_EN macro.
package rotor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STEP_HI,
      STEP_LO,
      SETTLE
   } ch_state_e;

   localparam logic DIR_FWD = 1'b1;

   // Width needed to hold 0..v-1, never narrower than one bit.
   function automatic int clog2w(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/rotor_channel.sv
// One rotor channel: position tracking, step pacing, direction setup and settle hold.
// With ROTOR_WRAP_EN defined the shortest path around the ring is taken.
module rotor_channel
   import rotor_pkg::*;
#(
   parameter int ANGLE_W    = 8,
   parameter int STEP_DIV   = 1000,
   parameter int SETTLE_CYC = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               accept_i,
   input  logic [ANGLE_W-1:0] target_i,
   output logic               step_o,
   output logic               dir_o,
   output logic               enable_o,
   output logic               busy_o
);

   localparam int CNT_MAX = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
   localparam int CNT_W   = clog2w(CNT_MAX);
   localparam logic [CNT_W-1:0]   DIV_LOAD    = CNT_W'(STEP_DIV - 1);
   localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [ANGLE_W-1:0] POS_ONE     = ANGLE_W'(1);

   ch_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ANGLE_W-1:0] pos_q, pos_d;
   logic [ANGLE_W-1:0] target_q, target_d;
   logic               dir_q, dir_d;
   logic               step_q, step_d;
   logic               busy_q, busy_d;
   logic               new_dir;
   logic [ANGLE_W-1:0] pos_step;

`ifdef ROTOR_WRAP_EN
   localparam logic [ANGLE_W-1:0] HALF_REV = {1'b1, {(ANGLE_W-1){1'b0}}};
   logic [ANGLE_W-1:0] delta;

   // Modular distance; exactly half a revolution resolves forward.
   assign delta   = target_i - pos_q;
   assign new_dir = (delta <= HALF_REV) ? DIR_FWD : ~DIR_FWD;
`else
   assign new_dir = (target_i > pos_q) ? DIR_FWD : ~DIR_FWD;
`endif

   assign pos_step = (dir_q == DIR_FWD) ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pos_q    <= '0;
         target_q <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos_q;
      target_d = target_q;
      dir_d    = dir_q;
      unique case (state_q)
         IDLE: begin
            if (accept_i) begin
               target_d = target_i;
               if (target_i != pos_q) begin
                  dir_d   = new_dir;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = STEP_HI;
            cnt_d   = DIV_LOAD;
         end
         STEP_HI: begin
            if (cnt_q == '0) begin
               state_d = STEP_LO;
               cnt_d   = DIV_LOAD;
               pos_d   = pos_step;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         STEP_LO: begin
            if (cnt_q == '0) begin
               if (pos_q == target_q) begin
                  state_d = SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end else begin
                  state_d = STEP_HI;
                  cnt_d   = DIV_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered from the next state so they change cleanly with it.
      step_d = (state_d == STEP_HI);
      busy_d = (state_d != IDLE);
   end

   assign step_o   = step_q;
   assign dir_o    = dir_q;
   assign enable_o = busy_q;
   assign busy_o   = busy_q;

endmodule

// File: rtl/rotor_step_driver.sv
// Multi-channel rotor step/direction driver: command decode, ready mux, idle flag.
// Define ROTOR_WRAP_EN for modulo (shortest-path) positioning in every channel.
module rotor_step_driver
   import rotor_pkg::*;
#(
   parameter int N_CH       = 32,
   parameter int ANGLE_W    = 8,
   parameter int STEP_DIV   = 1000,
   parameter int SETTLE_CYC = 50000,
   localparam int CH_W      = clog2w(N_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CH_W-1:0]    cmd_ch,
   input  logic [ANGLE_W-1:0] cmd_angle,
   output logic [N_CH-1:0]    step,
   output logic [N_CH-1:0]    dir,
   output logic [N_CH-1:0]    enable,
   output logic [N_CH-1:0]    busy,
   output logic               all_idle
);

   logic            ch_in_range;
   logic [N_CH-1:0] ch_accept;
   logic            all_idle_q;

   // Out-of-range channels always look ready so their commands are consumed and dropped.
   assign ch_in_range = (32'(cmd_ch) < N_CH);
   assign cmd_ready   = ch_in_range ? ~busy[cmd_ch] : 1'b1;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_accept[gi] = cmd_valid & cmd_ready & (cmd_ch == CH_W'(gi));

      rotor_channel #(
         .ANGLE_W   (ANGLE_W),
         .STEP_DIV  (STEP_DIV),
         .SETTLE_CYC(SETTLE_CYC)
      ) u_channel (
         .clk     (clk),
         .rst_n   (reset),
         .accept_i(ch_accept[gi]),
         .target_i(cmd_angle),
         .step_o  (step[gi]),
         .dir_o   (dir[gi]),
         .enable_o(enable[gi]),
         .busy_o  (busy[gi])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         all_idle_q <= 1'b0;
      end else begin
         all_idle_q <= ~|busy;
      end
   end

   assign all_idle = all_idle_q;

endmodule

// File: tb/tb_rotor_step_driver.sv
// Directed bench for rotor_step_driver (N_CH=4, ANGLE_W=8, STEP_DIV=2, SETTLE_CYC=3).
// Compile with ROTOR_WRAP_EN defined to exercise the wrap-around moves instead of linear ones.
module tb_rotor_step_driver;

   localparam int N_CH       = 4;
   localparam int ANGLE_W    = 8;
   localparam int STEP_DIV   = 2;
   localparam int SETTLE_CYC = 3;
   localparam int CH_W       = 2;

   logic               clk;
   logic               reset;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [CH_W-1:0]    cmd_ch;
   logic [ANGLE_W-1:0] cmd_angle;
   logic [N_CH-1:0]    step;
   logic [N_CH-1:0]    dir;
   logic [N_CH-1:0]    enable;
   logic [N_CH-1:0]    busy;
   logic               all_idle;

   int checks;
   int failures;

   rotor_step_driver #(
      .N_CH      (N_CH),
      .ANGLE_W   (ANGLE_W),
      .STEP_DIV  (STEP_DIV),
      .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_ch   (cmd_ch),
      .cmd_angle(cmd_angle),
      .step     (step),
      .dir      (dir),
      .enable   (enable),
      .busy     (busy),
      .all_idle (all_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one command for one edge; returns 1 time unit after that edge (cycle 1 of a move).
   task automatic send(input int ch, input int ang);
      cmd_valid = 1'b1;
      cmd_ch    = CH_W'(ch);
      cmd_angle = ANGLE_W'(ang);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      $display("cmd ch=%0d angle=%0d", ch, ang);
   endtask

   // Samples channel ch from the current cycle until busy falls or the cycle budget runs out.
   task automatic observe(input int ch, input int limit, output int blen, output int pulses,
                          output logic fdir, output logic dchg);
      logic prev_step;
      blen = 0; pulses = 0; fdir = 1'b0; dchg = 1'b0; prev_step = 1'b0;
      for (int c = 0; c < limit; c++) begin
         if (busy[ch] === 1'b1) begin
            if (blen == 0) fdir = dir[ch];
            else if (dir[ch] !== fdir) dchg = 1'b1;
            blen++;
         end
         if (step[ch] === 1'b1 && !prev_step) pulses++;
         prev_step = (step[ch] === 1'b1);
         if (blen > 0 && busy[ch] !== 1'b1) break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_angle = '0;
      #2;
      checks++;
      if ({step, dir, enable, busy, all_idle} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got step=%b dir=%b en=%b busy=%b idle=%b want all 0",
                  step, dir, enable, busy, all_idle);
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      checks++;
      if (all_idle !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_before_clk got %b want 0", all_idle);
      end
      @(posedge clk);
      #1;
      checks++;
      if (all_idle !== 1'b1 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_idle_after_clk got idle=%b ready=%b want 1 1", all_idle, cmd_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_step;
      logic exp_act, exp_step;
      send(0, 1);
      for (int c = 1; c <= 9; c++) begin
         exp_act  = (c <= 8);
         exp_step = (c == 2 || c == 3);
         checks++;
         if (busy[0] !== exp_act || enable[0] !== exp_act || step[0] !== exp_step ||
             (exp_act && dir[0] !== 1'b1)) begin
            failures++;
            $display("FAIL single_step cycle=%0d got busy=%b en=%b step=%b dir=%b want busy=%b en=%b step=%b dir=1",
                     c, busy[0], enable[0], step[0], dir[0], exp_act, exp_act, exp_step);
         end
         if (c == 1) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
               failures++;
               $display("FAIL single_step_ready got %b want 0", cmd_ready);
            end
         end
         if (c == 2) begin
            checks++;
            if (all_idle !== 1'b0) begin
               failures++;
               $display("FAIL single_step_all_idle got %b want 0", all_idle);
            end
         end
         @(posedge clk);
         #1;
      end
      $display("test_single_step done");
   endtask

   // Channel ch is expected to sit at ang already: no activity at all.
   task automatic test_same_pos(input int ch, input int ang);
      logic bad;
      bad = 1'b0;
      send(ch, ang);
      for (int c = 0; c < 8; c++) begin
         if (busy[ch] !== 1'b0 || enable[ch] !== 1'b0 || step[ch] !== 1'b0 || cmd_ready !== 1'b1)
            bad = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL same_pos ch=%0d angle=%0d channel became active, want idle", ch, ang);
      end
      $display("test_same_pos ch=%0d angle=%0d done", ch, ang);
   endtask

   task automatic test_move(input string name, input int ch, input int ang,
                            input int exp_steps, input logic exp_dir);
      int blen, pulses, exp_len;
      logic fdir, dchg;
      exp_len = 1 + 2 * STEP_DIV * exp_steps + SETTLE_CYC;
      send(ch, ang);
      observe(ch, exp_len + 20, blen, pulses, fdir, dchg);
      checks++;
      if (blen !== exp_len || pulses !== exp_steps || fdir !== exp_dir || dchg !== 1'b0) begin
         failures++;
         $display("FAIL %s got busy=%0d steps=%0d dir=%b dir_changed=%b want busy=%0d steps=%0d dir=%b dir_changed=0",
                  name, blen, pulses, fdir, dchg, exp_len, exp_steps, exp_dir);
      end
      $display("%s ch=%0d angle=%0d busy=%0d steps=%0d dir=%b", name, ch, ang, blen, pulses, fdir);
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int blen, pulses;
      logic fdir, dchg;
      send(2, 3);
      cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_angle = 8'd9;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_busy_ready got %b want 0", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_ch = 2'd3; cmd_angle = 8'd1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_other_ready got %b want 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checks++;
      if (busy[3] !== 1'b1 || dir[3] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ch3_accept got busy=%b dir=%b want 1 1", busy[3], dir[3]);
      end
      // Channel 2 is now in its third cycle of a 3-step forward move.
      observe(2, 40, blen, pulses, fdir, dchg);
      checks++;
      if (pulses !== 3 || fdir !== 1'b1 || blen !== 14) begin
         failures++;
         $display("FAIL b2b_ch2_move got steps=%0d dir=%b busy=%0d want steps=3 dir=1 busy=14",
                  pulses, fdir, blen);
      end
      $display("test_back_to_back ch2 steps=%0d", pulses);
      test_same_pos(2, 3);
      test_same_pos(3, 1);
   endtask

   task automatic test_reset_mid_move;
      send(1, 4);
      @(posedge clk);
      #1;
      checks++;
      if (step[1] !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_step_hi got %b want 1", step[1]);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({step, dir, enable, busy, all_idle} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs got step=%b dir=%b en=%b busy=%b idle=%b want all 0",
                  step, dir, enable, busy, all_idle);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (all_idle !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_all_idle got %b want 1", all_idle);
      end
      $display("test_reset_mid_move done");
      test_move("after_reset", 1, 1, 1, 1'b1);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single_step();
      test_same_pos(0, 1);
      test_move("ch1_fwd", 1, 5, 5, 1'b1);
      test_move("ch1_rev", 1, 2, 3, 1'b0);
      test_same_pos(1, 2);
      test_back_to_back();
`ifdef ROTOR_WRAP_EN
      test_move("wrap_back_to_250", 0, 250, 7, 1'b0);
      test_move("wrap_fwd_to_3", 0, 3, 9, 1'b1);
      test_move("wrap_back_to_0", 0, 0, 3, 1'b0);
      test_move("wrap_half_tie", 0, 128, 128, 1'b1);
`else
      test_move("lin_rev_to_0", 0, 0, 1, 1'b0);
      test_move("lin_fwd_to_3", 0, 3, 3, 1'b1);
      test_move("lin_fwd_to_250", 0, 250, 247, 1'b1);
`endif
      test_reset_mid_move();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
